ram_responder: RTL and testbench

- Memory-side responder for the main-memory bus that the memory controller drives as initiator.
- Owns a synchronous single-port block RAM of 2^ADDR_WIDTH words.
- Services fixed-length line bursts for the instruction and data caches, and variable-length stream transfers for external devices.
- Returns read beats, requests write beats, and flags the final beat with mem_last, so the controller can release the bus.

---
 rtl/ram_responder_pkg.sv | 9 +
 rtl/ram_responder_ram_sp.sv | 25 ++
 rtl/ram_responder.sv | 161 ++++++++++++++++
 tb/tb_ram_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_responder_pkg.sv
// Shared main-memory bus constants for the RAM responder slice.
package ram_responder_pkg;

   localparam int   ADDR_BUS_W = 32;
   localparam int   DATA_BUS_W = 32;
   localparam logic MEM_READ   = 1'b0;
   localparam logic MEM_WRITE  = 1'b1;

endpackage

// File: rtl/ram_responder_ram_sp.sv
// Single-port synchronous RAM, one-cycle read latency, read-old on write.
module ram_sp #(
   parameter int DW = 32,
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_responder.sv
// Memory-side bus responder: line bursts (critical-word-first) and
// variable-length streams over a single-port block RAM.
module ram_responder
   import ram_responder_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int BURST_LEN   = 8,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_BUS_W-1:0] mem_addr,
   input  logic                  mem_enable,
   input  logic                  mem_rw,
   input  logic                  mem_op_size,
   input  logic                  mem_finishes_op,
   input  logic [DATA_WIDTH-1:0] mem_write,
   output logic                  mem_write_req,
   output logic [DATA_WIDTH-1:0] mem_read,
   output logic                  mem_read_valid,
   output logic                  mem_last
);

   localparam int LW = $clog2(BURST_LEN);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_READ,
      ST_WRITE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH-1:0] r_beat;
   logic                  r_rw;
   logic                  r_op;
   logic [3:0]            r_wait;
   logic                  r_issued_all;
   logic                  r_rvalid;
   logic                  r_rlast;

   logic [ADDR_WIDTH-1:0] w_line_addr;
   logic [ADDR_WIDTH-1:0] w_strm_addr;
   logic [ADDR_WIDTH-1:0] w_ram_addr;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_line_end;
   logic                  w_last_flag;
   logic                  w_done;
   logic                  w_issue;
   logic                  w_unused;

   assign w_unused = ^{mem_addr[ADDR_BUS_W-1:ADDR_WIDTH+2], mem_addr[1:0]};

   // Line bursts wrap inside the aligned line; streams wrap the whole RAM.
   assign w_strm_addr = r_base + r_beat;
   assign w_line_addr = {r_base[ADDR_WIDTH-1:LW],
                         r_base[LW-1:0] + r_beat[LW-1:0]};
   assign w_ram_addr  = r_op ? w_strm_addr : w_line_addr;
   assign w_line_end  = (r_beat == ADDR_WIDTH'(BURST_LEN - 1));

   assign mem_write_req  = (r_state == ST_WRITE) & mem_enable;
   assign mem_read_valid = r_rvalid & mem_enable;
   assign mem_read       = mem_read_valid ? w_rdata : '0;

   // Read beats lag their issue by one cycle, so their line-end is pipelined.
   always_comb begin
      w_last_flag = 1'b0;
      if (r_op) begin
         w_last_flag = mem_finishes_op;
      end else if (r_state == ST_WRITE) begin
         w_last_flag = w_line_end;
      end else begin
         w_last_flag = r_rlast;
      end
   end

   assign w_done   = (mem_write_req | mem_read_valid) & w_last_flag;
   assign mem_last = w_done;
   assign w_issue  = (r_state == ST_READ) & mem_enable
                   & ~r_issued_all & ~w_done;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (mem_enable) begin
               if (WAIT_CYCLES > 0) begin
                  w_state_nxt = ST_WAIT;
               end else if (mem_rw == MEM_READ) begin
                  w_state_nxt = ST_READ;
               end else begin
                  w_state_nxt = ST_WRITE;
               end
            end
         end
         ST_WAIT: begin
            if (!mem_enable) begin
               w_state_nxt = ST_IDLE;
            end else if (r_wait == 4'd1) begin
               w_state_nxt = (r_rw == MEM_WRITE) ? ST_WRITE : ST_READ;
            end
         end
         ST_READ, ST_WRITE: begin
            if (!mem_enable || w_done) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_base       <= '0;
         r_beat       <= '0;
         r_rw         <= 1'b0;
         r_op         <= 1'b0;
         r_wait       <= '0;
         r_issued_all <= 1'b0;
         r_rvalid     <= 1'b0;
         r_rlast      <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_rvalid <= w_issue;
         r_rlast  <= w_issue & w_line_end;
         if (r_state == ST_IDLE && mem_enable) begin
            r_base       <= mem_addr[ADDR_WIDTH+1:2];
            r_rw         <= mem_rw;
            r_op         <= mem_op_size;
            r_beat       <= '0;
            r_wait       <= 4'(WAIT_CYCLES);
            r_issued_all <= 1'b0;
         end
         if (r_state == ST_WAIT) begin
            r_wait <= r_wait - 4'd1;
         end
         if (w_issue || mem_write_req) begin
            r_beat <= r_beat + 1'b1;
         end
         if (w_issue && w_line_end && !r_op) begin
            r_issued_all <= 1'b1;
         end
      end
   end

   ram_sp #(
      .DW (DATA_WIDTH),
      .AW (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (mem_write_req),
      .i_addr  (w_ram_addr),
      .i_wdata (mem_write),
      .o_rdata (w_rdata)
   );

endmodule

// File: tb/tb_ram_responder.sv
// Bench: two responders (0 and 3 wait states) driven from a transaction table.
module tb_ram_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sel;
   logic        en;
   logic        rw;
   logic        op;
   logic        fin;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic        req0, vld0, last0, req3, vld3, last3;
   logic [31:0] rd0, rd3;
   logic        o_req, o_vld, o_last;
   logic [31:0] o_rd;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          sel;
      bit          rw;
      bit          op;
      logic [31:0] addr;
      int          n;
      logic [31:0] d0;
      logic [31:0] step;
      int          abort_k;
      int          lat;
   } vec_t;

   typedef struct {
      bit          rd;
      logic [31:0] data;
      bit          last;
   } exp_t;

   vec_t        tbl [11];
   exp_t        q_exp [$];
   logic [31:0] mdl [int];

   always #5 clk = ~clk;

   ram_responder #(.WAIT_CYCLES(0)) dut0 (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_addr        (addr),
      .mem_enable      (en & ~sel),
      .mem_rw          (rw),
      .mem_op_size     (op),
      .mem_finishes_op (fin),
      .mem_write       (wdata),
      .mem_write_req   (req0),
      .mem_read        (rd0),
      .mem_read_valid  (vld0),
      .mem_last        (last0)
   );

   ram_responder #(.WAIT_CYCLES(3)) dut3 (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_addr        (addr),
      .mem_enable      (en & sel),
      .mem_rw          (rw),
      .mem_op_size     (op),
      .mem_finishes_op (fin),
      .mem_write       (wdata),
      .mem_write_req   (req3),
      .mem_read        (rd3),
      .mem_read_valid  (vld3),
      .mem_last        (last3)
   );

   assign o_req  = sel ? req3  : req0;
   assign o_vld  = sel ? vld3  : vld0;
   assign o_last = sel ? last3 : last0;
   assign o_rd   = sel ? rd3   : rd0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
      end
   endtask

   function automatic int word_of(vec_t v, int i);
      int base;
      base = int'(v.addr[17:2]);
      if (v.op) return (base + i) & 16'hFFFF;
      return (base & ~7) | ((base + i) & 7);
   endfunction

   task automatic chk_quiet(input string nm);
      chk(nm, {29'd0, o_req, o_vld, o_last}, 32'd0);
      chk({nm, "_rdata"}, o_rd, 32'd0);
   endtask

   task automatic run_txn(input vec_t v);
      int   nb;
      int   seen;
      int   key;
      bit   got;
      bit   done;
      bit   beat;
      exp_t e;
      nb = (v.abort_k > 0) ? v.abort_k : v.n;
      for (int i = 0; i < nb; i++) begin
         key = (v.sel ? 65536 : 0) + word_of(v, i);
         e.rd   = !v.rw;
         e.last = (v.abort_k == 0) && (i == v.n - 1);
         if (v.rw) begin
            mdl[key] = v.d0 + i * v.step;
            e.data   = '0;
         end else begin
            e.data = mdl.exists(key) ? mdl[key] : 32'hDEAD_BEEF;
         end
         q_exp.push_back(e);
      end
      seen = 0;
      got  = 0;
      done = 0;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         @(negedge clk);
         sel   = v.sel;
         en    = !(v.abort_k > 0 && seen >= v.abort_k);
         op    = v.op;
         rw    = (cyc == 0) ? v.rw : ~v.rw;
         addr  = (cyc == 0) ? v.addr : ~v.addr;
         fin   = v.op && (seen == v.n - 1);
         wdata = v.d0 + seen * v.step;
         #1;
         if (cyc == 0) chk_quiet("idle_at_start");
         if (!en) begin
            chk_quiet("abort_quiet");
            done = 1;
         end else begin
            beat = v.rw ? o_req : o_vld;
            chk("wrong_direction", {31'd0, v.rw ? o_vld : o_req}, 32'd0);
            if (beat) begin
               if (!got) chk("first_latency", cyc, v.lat);
               got = 1;
               if (q_exp.size() == 0) begin
                  chk("extra_beat", q_exp.size(), 1);
               end else begin
                  e = q_exp.pop_front();
                  if (e.rd) chk("rdata", o_rd, e.data);
                  chk("last_flag", {31'd0, o_last}, {31'd0, e.last});
               end
               if (o_last) done = 1;
               seen++;
            end else begin
               chk("no_beat_last", {31'd0, o_last}, 32'd0);
               if (got) chk("bubble", {31'd0, beat}, 32'd1);
            end
         end
      end
      chk("txn_timeout", {31'd0, done}, 32'd1);
      chk("sb_empty", q_exp.size(), 0);
      q_exp.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t rv;
      //        sel rw op addr          n  d0     step   abort lat
      tbl[0]  = '{0, 1, 0, 32'h14,       8, 32'hA0, 32'h1,  0, 1};
      tbl[1]  = '{0, 0, 0, 32'h14,       8, 32'h0,  32'h0,  0, 2};
      tbl[2]  = '{0, 0, 0, 32'h0,        8, 32'h0,  32'h0,  0, 2};
      tbl[3]  = '{1, 1, 0, 32'h0,        8, 32'hC0, 32'h1,  0, 4};
      tbl[4]  = '{1, 0, 0, 32'h0,        8, 32'h0,  32'h0,  0, 5};
      tbl[5]  = '{0, 1, 1, 32'h3FFF8,    3, 32'h11, 32'h11, 0, 1};
      tbl[6]  = '{0, 0, 1, 32'h3FFF8,    3, 32'h0,  32'h0,  0, 2};
      tbl[7]  = '{0, 1, 0, 32'h20,       8, 32'h50, 32'h1,  0, 1};
      tbl[8]  = '{0, 1, 0, 32'h20,       8, 32'h70, 32'h1,  3, 1};
      tbl[9]  = '{0, 0, 0, 32'h20,       8, 32'h0,  32'h0,  0, 2};
      tbl[10] = '{0, 0, 0, 32'h1234_0014, 8, 32'h0, 32'h0,  0, 2};

      sel = 0; en = 0; rw = 0; op = 0; fin = 0;
      addr = '0; wdata = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      sel = 0; #1 chk_quiet("reset_dut0");
      sel = 1; #1 chk_quiet("reset_dut3");
      sel = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 11; t++) begin
         run_txn(tbl[t]);
      end

      // Reset mid read burst, then confirm memory survived it.
      @(negedge clk);
      sel = 0; en = 1; rw = 0; op = 0; fin = 0; addr = 32'h14;
      repeat (4) @(negedge clk);
      #1 chk("pre_reset_valid", {31'd0, o_vld}, 32'd1);
      #1 rst_n = 1'b0;
      #1 chk_quiet("async_reset");
      en = 0;
      @(negedge clk);
      rst_n = 1'b1;
      rv = tbl[1];
      run_txn(rv);

      @(negedge clk);
      en = 0; fin = 0;
      #1 chk_quiet("final_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
